// File: rtl/cronometro_split_pkg.sv
// Shared definitions for the stopwatch core.
//  state_e    : FSM state encodings (IDLE / RUN / SPLIT / PAUSE)
//  bcd_to_seg : BCD digit -> 7-segment pattern, active-high, bit 0 = seg a .. bit 6 = seg g
package cronometro_split_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SPLIT = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  // Codes above 9 cannot occur in the counter; they decode to a blank digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/cronometro_split_debounce.sv
// Button conditioner: 2-FF synchroniser, counter-based debounce, press edge pulse.
//  clk, rst : system clock, synchronous active-high reset (clears to "released")
//  btn_raw  : raw asynchronous, bouncing button
//  level    : debounced level, 1 = pressed
//  press    : one-cycle pulse on the released -> pressed transition of level
// The debounced level follows the synchronised input only after DEB_MAX consecutive
// differing samples, so a settled input shows up on press DEB_MAX+2 edges after it
// is first captured.
module btn_debounce_edge #(
  parameter int DEB_MAX    = 5000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_MAX > 1) ? $clog2(DEB_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_MAX - 1);

  logic          btn_in_s;
  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Normalise polarity so the rest of the logic sees 1 = pressed.
  assign btn_in_s = ACTIVE_LOW ? ~btn_raw : btn_raw;

  // Synchroniser, stability counter, debounced level and press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= btn_in_s;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        // DEB_MAX-th consecutive differing sample: accept the new level.
        level_r <= sync2_r;
        press_r <= sync2_r;
        cnt_r   <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/cronometro_split.sv
// Stopwatch core: start/pause, split (lap freeze) and clear from two push-buttons.
//  clk, rst  : system clock, synchronous active-high reset
//  btn_start : raw start/pause button
//  btn_lap   : raw split/clear button
//  running   : 1 in RUN or SPLIT
//  frozen    : 1 in SPLIT (display shows the snapshot)
//  overflow  : sticky, counter wrapped past its maximum
//  bcd_out   : displayed value, digit i at [4i+3:4i], i=0 least significant
//  seg_out   : 7-segment code of bcd_out, digit i at [7i+6:7i], bit 7i = seg a
// The counter advances on a prescaler tick-enable; no derived clocks.
module cronometro_split
  import cronometro_split_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int TICK_HZ        = 1000,
  parameter int FRAC_DIGITS    = 3,
  parameter int SEC_DIGITS     = 2,
  parameter bit WRAP_60        = 1'b1,
  parameter int DEB_MAX        = 5000,
  parameter bit BTN_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      btn_start,
  input  logic                                      btn_lap,
  output logic                                      running,
  output logic                                      frozen,
  output logic                                      overflow,
  output logic [4*(FRAC_DIGITS+SEC_DIGITS)-1:0]     bcd_out,
  output logic [7*(FRAC_DIGITS+SEC_DIGITS)-1:0]     seg_out
);

  localparam int N        = FRAC_DIGITS + SEC_DIGITS;
  localparam int DIV      = CLK_FREQ / TICK_HZ;
  localparam int PW       = $clog2(DIV);
  localparam int TENS_IDX = FRAC_DIGITS + 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  state_e          state_r;
  state_e          state_next_s;
  logic            start_p_s;
  logic            lap_p_s;
  logic            start_level_s;
  logic            lap_level_s;
  logic            levels_unused_s;
  logic            counting_s;
  logic            tick_s;
  logic            clear_s;
  logic            take_snap_s;
  logic            wrap_s;
  logic            digit_carry_s;
  logic [3:0]      digit_lim_s;
  logic [PW-1:0]   presc_r;
  logic [4*N-1:0]  cnt_r;
  logic [4*N-1:0]  cnt_next_s;
  logic [4*N-1:0]  snap_r;
  logic            overflow_r;

  btn_debounce_edge #(.DEB_MAX(DEB_MAX), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_deb_start (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_start),
    .level   (start_level_s),
    .press   (start_p_s)
  );

  btn_debounce_edge #(.DEB_MAX(DEB_MAX), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_deb_lap (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_lap),
    .level   (lap_level_s),
    .press   (lap_p_s)
  );

  // Held button levels are not needed by the FSM, only the press pulses.
  assign levels_unused_s = start_level_s ^ lap_level_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start wins when both pulses arrive in the same cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_p_s) state_next_s = ST_RUN;   else state_next_s = ST_IDLE;
      ST_RUN:   if (start_p_s) state_next_s = ST_PAUSE;
                else if (lap_p_s) state_next_s = ST_SPLIT;
                else state_next_s = ST_RUN;
      ST_SPLIT: if (start_p_s) state_next_s = ST_PAUSE;
                else if (lap_p_s) state_next_s = ST_RUN;
                else state_next_s = ST_SPLIT;
      ST_PAUSE: if (start_p_s) state_next_s = ST_RUN;
                else if (lap_p_s) state_next_s = ST_IDLE;
                else state_next_s = ST_PAUSE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  assign counting_s  = (state_r == ST_RUN) || (state_r == ST_SPLIT);
  assign tick_s      = counting_s && (presc_r == PRE_LAST);
  assign clear_s     = (state_r == ST_PAUSE) && lap_p_s && !start_p_s;
  assign take_snap_s = (state_r == ST_RUN) && lap_p_s && !start_p_s;

  // Prescaler: counts while running, holds in PAUSE, zero in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= {PW{1'b0}};
    end else if (counting_s) begin
      presc_r <= (presc_r == PRE_LAST) ? {PW{1'b0}} : presc_r + PW'(1);
    end else if ((state_r == ST_IDLE) || clear_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r;
    end
  end

  // BCD ripple increment; the carry out of the top digit marks a full wrap.
  always_comb begin
    cnt_next_s    = cnt_r;
    digit_carry_s = tick_s;
    digit_lim_s   = 4'd9;
    for (int i = 0; i < N; i++) begin
      digit_lim_s = (WRAP_60 && (i == TENS_IDX)) ? 4'd5 : 4'd9;
      if (digit_carry_s) begin
        if (cnt_r[4*i +: 4] == digit_lim_s) begin
          cnt_next_s[4*i +: 4] = 4'd0;
          digit_carry_s        = 1'b1;
        end else begin
          cnt_next_s[4*i +: 4] = cnt_r[4*i +: 4] + 4'd1;
          digit_carry_s        = 1'b0;
        end
      end else begin
        digit_carry_s = 1'b0;
      end
    end
    wrap_s = digit_carry_s;
  end

  // Live counter and sticky overflow; both cleared when PAUSE returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {(4*N){1'b0}};
      overflow_r <= 1'b0;
    end else if (clear_s) begin
      cnt_r      <= {(4*N){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_next_s;
      overflow_r <= overflow_r | wrap_s;
    end
  end

  // Snapshot captures the pre-increment live value on the RUN -> SPLIT edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_r <= {(4*N){1'b0}};
    end else if (take_snap_s) begin
      snap_r <= cnt_r;
    end else begin
      snap_r <= snap_r;
    end
  end

  assign running  = counting_s;
  assign frozen   = (state_r == ST_SPLIT);
  assign overflow = overflow_r;
  assign bcd_out  = frozen ? snap_r : cnt_r;

  for (genvar g = 0; g < N; g++) begin : g_seg
    logic [6:0] seg_hi_s;
    assign seg_hi_s              = bcd_to_seg(bcd_out[4*g +: 4]);
    assign seg_out[7*g +: 7]     = SEG_ACTIVE_LOW ? ~seg_hi_s : seg_hi_s;
  end

endmodule

// File: tb/tb_cronometro_split.sv
// Directed bench for cronometro_split. Main instance: DIV=10, DEB_MAX=4, 3+2 digits,
// active-low buttons and segments. Two small instances (1+2 digits, DIV=2) cover the
// 59.9 / 99.9 wrap and overflow within a short run.
module tb_cronometro_split;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        btn_start, btn_lap, btn_start2, btn_lap2;
  logic        running, frozen, overflow;
  logic [19:0] bcd_out;
  logic [34:0] seg_out;
  logic        r60, f60, o60, r99, f99, o99;
  logic [11:0] b60, b99;
  logic [20:0] s60, s99;

  cronometro_split #(.CLK_FREQ(100), .TICK_HZ(10), .FRAC_DIGITS(3), .SEC_DIGITS(2),
    .WRAP_60(1'b1), .DEB_MAX(4), .BTN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_lap(btn_lap), .running(running),
    .frozen(frozen), .overflow(overflow), .bcd_out(bcd_out), .seg_out(seg_out));

  cronometro_split #(.CLK_FREQ(100), .TICK_HZ(50), .FRAC_DIGITS(1), .SEC_DIGITS(2),
    .WRAP_60(1'b1), .DEB_MAX(4), .BTN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_w60 (
    .clk(clk), .rst(rst), .btn_start(btn_start2), .btn_lap(btn_lap2), .running(r60),
    .frozen(f60), .overflow(o60), .bcd_out(b60), .seg_out(s60));

  cronometro_split #(.CLK_FREQ(100), .TICK_HZ(50), .FRAC_DIGITS(1), .SEC_DIGITS(2),
    .WRAP_60(1'b0), .DEB_MAX(4), .BTN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_w99 (
    .clk(clk), .rst(rst), .btn_start(btn_start2), .btn_lap(btn_lap2), .running(r99),
    .frozen(f99), .overflow(o99), .bcd_out(b99), .seg_out(s99));

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  // Reference model of the main instance: 0 IDLE, 1 RUN, 2 SPLIT, 3 PAUSE.
  int k_run     = 0;  // edges seen while counting (prescaler steps)
  int exp_state = 0;
  int snap_cnt  = 0;

  function automatic int cnt_of(input int k);
    return (k / 10) % 60000;
  endfunction

  function automatic logic [19:0] bcd5(input int v);
    logic [19:0] r;
    int          t;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_lo(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic sb_push(input string tag, input logic [63:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [63:0] obs);
    sb_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %0h expected nothing", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    sb_push(tag, exp);
    sb_pop_check(obs);
  endtask

  // Advance n clock edges, accumulating prescaler steps while the model is counting;
  // ends 1 time unit after the last edge so sampling and driving are away from it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (exp_state == 1 || exp_state == 2) k_run++;
    end
    #1;
  endtask

  task automatic check_main(input string tag);
    logic [19:0] eb;
    logic [34:0] es;
    int          v;
    v  = (exp_state == 2) ? snap_cnt : cnt_of(k_run);
    eb = bcd5(v);
    for (int i = 0; i < 5; i++) es[7*i +: 7] = seg_lo(eb[4*i +: 4]);
    sb_push({tag, ".running"},  {63'd0, (exp_state == 1 || exp_state == 2)});
    sb_push({tag, ".frozen"},   {63'd0, (exp_state == 2)});
    sb_push({tag, ".overflow"}, {63'd0, ((k_run / 10) >= 60000)});
    sb_push({tag, ".bcd"},      {44'd0, eb});
    sb_push({tag, ".seg"},      {29'd0, es});
    sb_pop_check({63'd0, running});
    sb_pop_check({63'd0, frozen});
    sb_pop_check({63'd0, overflow});
    sb_pop_check({44'd0, bcd_out});
    sb_pop_check({29'd0, seg_out});
  endtask

  // Hold raw buttons pressed until the FSM reacts (DEB_MAX+3 edges), updating the model.
  task automatic press(input bit s, input bit l);
    int k_before;
    if (s) btn_start = 1'b0;
    if (l) btn_lap   = 1'b0;
    step(6);
    k_before = k_run;
    step(1);
    case (exp_state)
      0: if (s) exp_state = 1;
      1: if (s) exp_state = 3;
         else if (l) begin exp_state = 2; snap_cnt = cnt_of(k_before); end
      2: if (s) exp_state = 3;
         else if (l) exp_state = 1;
      3: if (s) exp_state = 1;
         else if (l) begin exp_state = 0; k_run = 0; end
      default: exp_state = 0;
    endcase
  endtask

  task automatic release_all();
    btn_start = 1'b1;
    btn_lap   = 1'b1;
    step(8);
  endtask

  initial begin
    btn_start = 1'b1; btn_lap = 1'b1; btn_start2 = 1'b1; btn_lap2 = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check_main("reset");

    // Start: no reaction after 6 edges, RUN on the 7th.
    btn_start = 1'b0;
    step(6);
    check_main("start_early");
    step(1);
    exp_state = 1;
    check_main("start_7");
    step(250);
    check_main("run_025");

    // Split freezes the display, second lap releases it.
    release_all();
    press(1'b0, 1'b1);
    check_main("split");
    step(200);
    check_main("split_hold");
    release_all();
    press(1'b0, 1'b1);
    check_main("unsplit");

    // Pause holds value and prescaler phase across a long stop.
    release_all();
    press(1'b1, 1'b0);
    check_main("pause");
    step(1000);
    check_main("pause_hold");
    release_all();
    press(1'b1, 1'b0);
    step(37);
    check_main("resume");
    release_all();
    press(1'b1, 1'b0);
    release_all();
    press(1'b0, 1'b1);
    check_main("clear_idle");

    // Simultaneous start+lap in RUN pauses without a snapshot.
    release_all();
    press(1'b1, 1'b0);
    release_all();
    step(123);
    press(1'b1, 1'b1);
    check_main("both_pause");
    release_all();

    // A 3-cycle lap glitch in PAUSE must not clear.
    btn_lap = 1'b0;
    step(3);
    btn_lap = 1'b1;
    step(10);
    check_main("glitch");

    // Reset while in SPLIT.
    press(1'b1, 1'b0);
    release_all();
    step(15);
    press(1'b0, 1'b1);
    check_main("pre_rst_split");
    release_all();
    rst = 1'b1;
    step(1);
    exp_state = 0; k_run = 0; snap_cnt = 0;
    check_main("rst_split");
    rst = 1'b0;

    // Wrap instances: one count per 2 edges once running.
    btn_start2 = 1'b0;
    step(7);
    chk("w60.running", {63'd0, r60}, 64'd1);
    step(1198);
    chk("w60.bcd_599", {52'd0, b60}, 64'h599);
    chk("w60.ovf_599", {63'd0, o60}, 64'd0);
    chk("w99.bcd_599", {52'd0, b99}, 64'h599);
    step(2);
    chk("w60.bcd_wrap", {52'd0, b60}, 64'h000);
    chk("w60.ovf_wrap", {63'd0, o60}, 64'd1);
    chk("w60.seg_wrap", {43'd0, s60}, {43'd0, {3{7'b1000000}}});
    chk("w99.bcd_600",  {52'd0, b99}, 64'h600);
    chk("w99.ovf_600",  {63'd0, o99}, 64'd0);
    step(2);
    chk("w60.bcd_001", {52'd0, b60}, 64'h001);
    chk("w60.run_ovf", {63'd0, r60}, 64'd1);
    step(796);
    chk("w99.bcd_999", {52'd0, b99}, 64'h999);
    chk("w99.ovf_999", {63'd0, o99}, 64'd0);
    chk("w60.bcd_399", {52'd0, b60}, 64'h399);
    step(2);
    chk("w99.bcd_wrap", {52'd0, b99}, 64'h000);
    chk("w99.ovf_wrap", {63'd0, o99}, 64'd1);
    chk("w60.bcd_400",  {52'd0, b60}, 64'h400);
    chk("w60.ovf_sticky", {63'd0, o60}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
